// File: rtl/julia_pkg.sv
// Shared definitions for the Julia-set renderer: fixed-point format,
// iteration cap, scanner states and the RGB332 pixel type.
package julia_pkg;

    localparam int FRAC_BITS      = 13;
    localparam int ONE            = 1 << FRAC_BITS;
    localparam int ITER_LIMIT_DEF = 100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_GUARD,
        S_WAIT,
        S_WRITE,
        S_ADVANCE
    } scan_state_t;

    typedef logic [7:0] rgb332_t;

endpackage

// File: rtl/julia_palette.sv
// Maps an escape-time iteration count to an RGB332 colour; points inside
// the set (or bogus negative counts) are black, everything else is non-zero.
module julia_palette
    import julia_pkg::*;
#(
    parameter int ITER_LIMIT = ITER_LIMIT_DEF
) (
    input  logic signed [31:0] i_count,
    output rgb332_t            o_rgb
);

    always_comb begin
        o_rgb = 8'h00;
        if (i_count >= 0 && i_count < ITER_LIMIT)
            o_rgb = {i_count[2:0], i_count[5:3], i_count[6], 1'b1};
    end

endmodule

// File: rtl/julia_scan.sv
// Raster pixel sequencer: seeds the escape-time calculator one pixel at a
// time, waits for its result and writes the coloured pixel to the frame buffer.
module julia_scan
    import julia_pkg::*;
#(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ITER_LIMIT = ITER_LIMIT_DEF,
    parameter int TIMEOUT    = 4096
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               FRAME_START,
    input  logic signed [31:0] ORIGIN_R,
    input  logic signed [31:0] ORIGIN_I,
    input  logic signed [31:0] STEP,
    input  logic signed [31:0] C_R,
    input  logic signed [31:0] C_I,
    output logic signed [31:0] ZR,
    output logic signed [31:0] ZI,
    output logic signed [31:0] CR,
    output logic signed [31:0] CI,
    output logic               CALC_START,
    input  logic               CALC_END,
    input  logic signed [31:0] CALC_NUM,
    output logic               WR_EN,
    output logic [18:0]        WR_ADDR,
    output logic [7:0]         WR_DATA,
    input  logic               FB_READY,
    output logic               BUSY,
    output logic               FRAME_DONE,
    output logic               ERR
);

    localparam int X_W  = $clog2(H_RES + 1);
    localparam int Y_W  = $clog2(V_RES + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [X_W-1:0]  X_LAST  = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(V_RES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    scan_state_t        r_state, w_next;
    logic signed [31:0] r_org_r, r_org_i, r_step, r_c_r, r_c_i;
    logic signed [31:0] r_zr, r_zi, r_cr, r_ci;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [18:0]        r_addr;
    rgb332_t            r_wdata;
    logic [TO_W-1:0]    r_wdog;
    logic               r_err;
    logic               w_x_last, w_y_last, w_timeout;
    logic signed [31:0] w_count;
    rgb332_t            w_pix;

    assign w_x_last  = (r_x == X_LAST);
    assign w_y_last  = (r_y == Y_LAST);
    assign w_timeout = (r_state == S_WAIT) && !CALC_END && (r_wdog == TO_LAST);
    // A timed-out pixel is painted as if it never escaped.
    assign w_count   = w_timeout ? ITER_LIMIT : CALC_NUM;

    julia_palette #(.ITER_LIMIT(ITER_LIMIT)) u_palette (
        .i_count (w_count),
        .o_rgb   (w_pix)
    );

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        CALC_START = 1'b0;
        WR_EN      = 1'b0;
        FRAME_DONE = 1'b0;
        case (r_state)
            S_IDLE:    if (FRAME_START) w_next = S_LOAD;
            S_LOAD:    w_next = S_START;
            S_START: begin
                CALC_START = 1'b1;
                w_next     = S_GUARD;
            end
            // The calculator drops its done flag only after seeing start.
            S_GUARD:   w_next = S_WAIT;
            S_WAIT:    if (CALC_END || w_timeout) w_next = S_WRITE;
            S_WRITE: begin
                WR_EN = 1'b1;
                if (FB_READY) w_next = S_ADVANCE;
            end
            S_ADVANCE: begin
                if (w_x_last && w_y_last) begin
                    FRAME_DONE = 1'b1;
                    w_next     = S_IDLE;
                end else begin
                    w_next = S_START;
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_zr    <= '0;
            r_zi    <= '0;
            r_cr    <= '0;
            r_ci    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wdog  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (FRAME_START) begin
                        r_org_r <= ORIGIN_R;
                        r_org_i <= ORIGIN_I;
                        r_step  <= STEP;
                        r_c_r   <= C_R;
                        r_c_i   <= C_I;
                        r_err   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_x    <= '0;
                    r_y    <= '0;
                    r_addr <= '0;
                    r_zr   <= r_org_r;
                    r_zi   <= r_org_i;
                    r_cr   <= r_c_r;
                    r_ci   <= r_c_i;
                end
                S_GUARD: r_wdog <= '0;
                S_WAIT: begin
                    if (CALC_END || w_timeout) r_wdata <= w_pix;
                    else                       r_wdog  <= r_wdog + 1'b1;
                    if (w_timeout) r_err <= 1'b1;
                end
                S_ADVANCE: begin
                    if (!w_x_last) begin
                        r_x    <= r_x + 1'b1;
                        r_zr   <= r_zr + r_step;
                        r_addr <= r_addr + 19'd1;
                    end else if (!w_y_last) begin
                        r_x    <= '0;
                        r_y    <= r_y + 1'b1;
                        r_zr   <= r_org_r;
                        r_zi   <= r_zi - r_step;
                        r_addr <= r_addr + 19'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ZR      = r_zr;
    assign ZI      = r_zi;
    assign CR      = r_cr;
    assign CI      = r_ci;
    assign WR_ADDR = r_addr;
    assign WR_DATA = r_wdata;
    assign BUSY    = (r_state != S_IDLE);
    assign ERR     = r_err;

endmodule

// File: tb/tb_julia_scan.sv
// Directed bench for julia_scan on a 4x3 raster with a behavioural calculator
// and a scoreboard of expected seeds and frame-buffer writes.
module tb_julia_scan;

    localparam int H = 4;
    localparam int V = 3;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               FRAME_START = 1'b0;
    logic signed [31:0] ORIGIN_R = '0, ORIGIN_I = '0, STEP = '0, C_R = '0, C_I = '0;
    logic signed [31:0] ZR, ZI, CR, CI;
    logic               CALC_START;
    logic               CALC_END = 1'b0;
    logic signed [31:0] CALC_NUM = '0;
    logic               WR_EN;
    logic [18:0]        WR_ADDR;
    logic [7:0]         WR_DATA;
    logic               FB_READY = 1'b1;
    logic               BUSY, FRAME_DONE, ERR;

    julia_scan #(.H_RES(H), .V_RES(V), .ITER_LIMIT(100), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .FRAME_START(FRAME_START),
        .ORIGIN_R(ORIGIN_R), .ORIGIN_I(ORIGIN_I), .STEP(STEP), .C_R(C_R), .C_I(C_I),
        .ZR(ZR), .ZI(ZI), .CR(CR), .CI(CI),
        .CALC_START(CALC_START), .CALC_END(CALC_END), .CALC_NUM(CALC_NUM),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .FB_READY(FB_READY),
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    // Frame parameters and calculator behaviour chosen by the stimulus.
    int fr_org_r, fr_org_i, fr_step, fr_c_r, fr_c_i;
    int cmode = 0;   // 0: answer after cdly cycles, 1: never answer, 2: done held high
    int cdly = 3;
    int cval = 5;
    int exp_val = 5;
    int exp_gap = 4;

    // Scoreboard state, written only by the compare process.
    int seed_idx = 0, wr_idx = 0, done_cnt = 0, cyc = 0, start_cyc = 0;
    logic               prev_wr = 1'b0, prev_rdy = 1'b1;
    logic [18:0]        prev_addr = '0;
    logic [7:0]         prev_data = '0;
    logic signed [31:0] last_zr = '0, last_zi = '0;
    logic [7:0]         last_data = '0;

    logic seen = 1'b0;
    int   k = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pal(input int c);
        if (c < 0 || c >= 100) return 8'h00;
        return 8'((c % 8) * 32 + ((c / 8) % 8) * 4 + ((c / 64) % 2) * 2 + 1);
    endfunction

    // Behavioural escape-time calculator.
    initial begin
        forever begin
            @(negedge CLK);
            seen = CALC_START;
            @(posedge CLK);
            #1;
            if (seen) k = 1;
            else if (k > 0 && k < 1000) k++;
            case (cmode)
                1: begin
                    CALC_END = 1'b0;
                    CALC_NUM = 0;
                end
                2: begin
                    CALC_END = 1'b1;
                    if (k == 1) CALC_NUM = 200;
                    else if (k >= 2) CALC_NUM = 9;
                end
                default: begin
                    if (k >= 1) begin
                        if (k >= cdly) begin
                            CALC_END = 1'b1;
                            CALC_NUM = cval;
                        end else begin
                            CALC_END = 1'b0;
                            CALC_NUM = 200;
                        end
                    end
                end
            endcase
        end
    end

    // Compare process: seeds, waits, write hold and writes against the raster model.
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST) begin
                if (FRAME_START && !BUSY) begin
                    seed_idx = 0;
                    wr_idx   = 0;
                    done_cnt = 0;
                end
                if (CALC_START) begin
                    check("seed_zr", ZR, fr_org_r + (seed_idx % H) * fr_step);
                    check("seed_zi", ZI, fr_org_i - (seed_idx / H) * fr_step);
                    check("seed_cr", CR, fr_c_r);
                    check("seed_ci", CI, fr_c_i);
                    last_zr   = ZR;
                    last_zi   = ZI;
                    seed_idx++;
                    start_cyc = cyc;
                end
                if (WR_EN && !prev_wr)
                    check("start_to_write_cycles", cyc - start_cyc, exp_gap);
                if (prev_wr && !prev_rdy) begin
                    check("write_held_en", WR_EN, 1'b1);
                    check("write_held_addr", WR_ADDR, prev_addr);
                    check("write_held_data", WR_DATA, prev_data);
                end
                if (WR_EN && FB_READY) begin
                    check("write_addr", WR_ADDR, wr_idx);
                    check("write_data", WR_DATA, pal(exp_val));
                    last_data = WR_DATA;
                    wr_idx++;
                end
                if (FRAME_DONE) begin
                    check("done_after_last_write", wr_idx, H * V);
                    done_cnt++;
                end
            end
            prev_wr   = WR_EN;
            prev_rdy  = FB_READY;
            prev_addr = WR_ADDR;
            prev_data = WR_DATA;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got running, required finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_frame(input int orr, input int ori, input int st, input int cr, input int ci);
        fr_org_r = orr; fr_org_i = ori; fr_step = st; fr_c_r = cr; fr_c_i = ci;
        ORIGIN_R = orr; ORIGIN_I = ori; STEP = st; C_R = cr; C_I = ci;
    endtask

    task automatic calc(input int mode, input int dly, input int val, input int ev, input int gap);
        cmode = mode; cdly = dly; cval = val; exp_val = ev; exp_gap = gap;
    endtask

    task automatic start_frame;
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            if (FRAME_DONE) begin
                n = i;
                break;
            end
        end
        if (n == 0) check("frame_done_within_budget", 0, 1);
    endtask

    task automatic run_frame(input int budget);
        int n;
        start_frame();
        wait_done(budget, n);
        tick();
        tick();
        check("frame_write_count", wr_idx, H * V);
        check("frame_done_count", done_cnt, 1);
    endtask

    initial begin
        int n;
        int starts;
        repeat (3) tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_calc_start", CALC_START, 0);
        check("rst_wr_en", WR_EN, 0);
        check("rst_wr_addr", WR_ADDR, 0);
        check("rst_wr_data", WR_DATA, 0);
        check("rst_zr", ZR, 0);
        check("rst_zi", ZI, 0);
        check("rst_cr", CR, 0);
        check("rst_ci", CI, 0);
        check("rst_busy", BUSY, 0);
        check("rst_frame_done", FRAME_DONE, 0);
        check("rst_err", ERR, 0);
        tick();

        // Baseline frame; inputs are scrambled mid-frame and must be ignored.
        set_frame(-8192, 8192, 4096, 1234, -5678);
        calc(0, 3, 5, 5, 4);
        start_frame();
        @(negedge CLK);
        check("load_busy", BUSY, 1);
        check("load_no_start", CALC_START, 0);
        ORIGIN_R = 32'sh1234_5678; ORIGIN_I = -32'sd99; STEP = 32'sd7; C_R = 32'sd1; C_I = 32'sd2;
        @(negedge CLK);
        check("first_calc_start_latency", CALC_START, 1);
        wait_done(400, n);
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
        @(negedge CLK);
        check("start_on_done_ignored", BUSY, 0);
        check("frame_done_count", done_cnt, 1);
        check("frame_write_count", wr_idx, 12);
        check("last_seed_zr", last_zr, 4096);
        check("last_seed_zi", last_zi, 0);
        check("count5_colour", last_data, 8'hA1);
        tick();

        set_frame(-8192, 8192, 4096, 1234, -5678);
        calc(0, 3, 100, 100, 4);
        run_frame(400);
        check("inside_set_colour", last_data, 8'h00);

        // Fastest pixel: done already high at the first wait cycle.
        calc(0, 2, 0, 0, 3);
        start_frame();
        wait_done(400, n);
        check("min_frame_cycles", n, 61);
        tick();
        check("count0_colour", last_data, 8'h01);

        set_frame(40000, -12000, -300, 77, 88);
        calc(0, 3, 70, 70, 4);
        run_frame(400);
        check("count70_colour", last_data, 8'hC3);

        calc(0, 3, -3, -3, 4);
        run_frame(400);
        check("negative_count_colour", last_data, 8'h00);

        // Frame buffer stalls pixel 2 for seven cycles.
        set_frame(-8192, 8192, 4096, 1234, -5678);
        calc(0, 3, 5, 5, 4);
        start_frame();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (WR_EN && WR_ADDR == 19'd1) begin
                n = 1;
                break;
            end
        end
        check("pixel1_write_seen", n, 1);
        tick();
        FB_READY = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (WR_EN) begin
                n = 1;
                break;
            end
        end
        check("pixel2_write_seen", n, 1);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge CLK);
            check("stall_wr_en", WR_EN, 1);
            check("stall_wr_addr", WR_ADDR, 2);
            check("stall_no_calc_start", CALC_START, 0);
        end
        tick();
        FB_READY = 1'b1;
        wait_done(400, n);
        tick();
        tick();
        check("stall_frame_write_count", wr_idx, 12);

        // Calculator never answers: every pixel times out.
        calc(1, 3, 0, 100, 18);
        run_frame(1000);
        check("timeout_colour", last_data, 8'h00);
        check("timeout_err_set", ERR, 1);
        repeat (5) tick();
        check("timeout_err_sticky", ERR, 1);

        // Reset during the wait of pixel 5 abandons the pixel.
        calc(0, 3, 5, 5, 4);
        start_frame();
        @(negedge CLK);
        check("err_cleared_on_start", ERR, 0);
        starts = 0;
        for (int i = 0; i < 300; i++) begin
            if (CALC_START) starts++;
            if (starts == 6) break;
            @(negedge CLK);
        end
        check("pixel5_start_seen", starts, 6);
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_wr_en", WR_EN, 0);
        check("midrst_calc_start", CALC_START, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_wr_addr", WR_ADDR, 0);
        check("midrst_no_pixel5_write", wr_idx, 5);
        tick();
        run_frame(400);

        // Done held high across pixels; result appears two cycles after start.
        calc(2, 2, 9, 9, 3);
        tick();
        run_frame(400);
        check("held_done_colour", last_data, 8'h25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
